// File: rtl/iq_issue_select_pkg.sv
// Shared core definitions for the issue-select slice: default sizes and the
// wrap-aware age comparison used by every age-ordered picker.
package iq_issue_select_pkg;

    localparam int CIQ_DEPTH_DEF = 16;
    localparam int ISSUE_NUM_DEF = 4;
    localparam int AGE_DEF       = 5;
    localparam int IDX_W_DEF     = 4;

    // Age stamps are a wrapping counter, so "older" means the modular
    // difference a - b lands in the upper half of the range. Callers pass
    // zero-extended stamps and the index of the stamp MSB.
    function automatic logic age_older(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [4:0]  msb);
        logic [31:0] diff;
        diff = a - b;
        return diff[msb];
    endfunction

endpackage

// File: rtl/iq_age_pick.sv
// Oldest-entry picker: scans a candidate mask and returns the index of the
// oldest candidate (ties resolved toward the lower index) plus a found flag.
module iq_age_pick
    import iq_issue_select_pkg::*;
#(
    parameter int CIQ_DEPTH = CIQ_DEPTH_DEF,
    parameter int AGE       = AGE_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic [CIQ_DEPTH-1:0]          cand,
    input  logic [CIQ_DEPTH-1:0][AGE-1:0] ent_age,
    output logic                          found,
    output logic [IDX_W-1:0]              idx
);

    logic [AGE-1:0] best_age;

    // Linear scan; a later entry only replaces the current best when strictly
    // older, which keeps the lower index on equal ages.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        best_age = '0;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (cand[i] && (!found ||
                age_older(32'(ent_age[i]), 32'(best_age), 5'(AGE - 1)))) begin
                found    = 1'b1;
                idx      = IDX_W'(i);
                best_age = ent_age[i];
            end
        end
    end

endmodule

// File: rtl/iq_issue_select.sv
// Issue select: fills free issue ports with the oldest ready entries of the
// issue queue, holds a port under functional-unit backpressure, and presents
// the grant handshake combinationally from the port registers.
module iq_issue_select
    import iq_issue_select_pkg::*;
#(
    parameter int CIQ_DEPTH = CIQ_DEPTH_DEF,
    parameter int ISSUE_NUM = ISSUE_NUM_DEF,
    parameter int AGE       = AGE_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [CIQ_DEPTH-1:0]            ent_busy,
    input  logic [CIQ_DEPTH-1:0]            ent_issued,
    input  logic [CIQ_DEPTH-1:0]            ent_rdy,
    input  logic [CIQ_DEPTH-1:0][AGE-1:0]   ent_age,
    input  logic [ISSUE_NUM-1:0]            fu_ready,
    output logic [ISSUE_NUM-1:0]            issue_valid,
    output logic [ISSUE_NUM-1:0][IDX_W-1:0] issue_addr,
    output logic [ISSUE_NUM-1:0]            arbit_grant,
    output logic [ISSUE_NUM-1:0][IDX_W-1:0] arbit_addr
);

    logic [ISSUE_NUM-1:0]            valid_q;
    logic [ISSUE_NUM-1:0][IDX_W-1:0] addr_q;
    logic [CIQ_DEPTH-1:0]            cand;
    logic [ISSUE_NUM-1:0]            port_free;
    logic [ISSUE_NUM:0][CIQ_DEPTH-1:0] pick_mask;
    logic [ISSUE_NUM-1:0]            pick_found;
    logic [ISSUE_NUM-1:0][IDX_W-1:0] pick_idx;

    // Ready, not yet granted entries, minus whatever a port already holds.
    always_comb begin
        cand = ent_busy & ent_rdy & ~ent_issued;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (valid_q[j]) begin
                cand[addr_q[j]] = 1'b0;
            end
        end
    end

    assign port_free    = ~valid_q | fu_ready;
    assign pick_mask[0] = cand;

    // One picker per port; a winner is removed from later pickers only when
    // its port actually loads, so held ports never consume a candidate.
    for (genvar j = 0; j < ISSUE_NUM; j++) begin : g_pick
        iq_age_pick #(
            .CIQ_DEPTH (CIQ_DEPTH),
            .AGE       (AGE),
            .IDX_W     (IDX_W)
        ) u_pick (
            .cand    (pick_mask[j]),
            .ent_age (ent_age),
            .found   (pick_found[j]),
            .idx     (pick_idx[j])
        );

        assign pick_mask[j+1] = (port_free[j] && pick_found[j])
                              ? (pick_mask[j] & ~(CIQ_DEPTH'(1) << pick_idx[j]))
                              : pick_mask[j];
    end

    // Port registers: flush empties every port, otherwise free ports reload
    // (or go empty) and stalled ports keep their entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                if (port_free[j]) begin
                    valid_q[j] <= pick_found[j];
                    if (pick_found[j]) begin
                        addr_q[j] <= pick_idx[j];
                    end
                end
            end
        end
    end

    assign issue_valid = valid_q;
    assign issue_addr  = addr_q;
    assign arbit_grant = flush ? '0 : (valid_q & fu_ready);
    assign arbit_addr  = addr_q;

endmodule

// File: tb/tb_iq_issue_select.sv
// Directed bench for iq_issue_select: each step pushes its expected port
// state to a scoreboard queue, advances, then pops and compares.
module tb_iq_issue_select;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic [15:0]           ent_busy;
    logic [15:0]           ent_issued;
    logic [15:0]           ent_rdy;
    logic [15:0][4:0]      ent_age;
    logic [3:0]            fu_ready;
    logic [3:0]            issue_valid;
    logic [3:0][3:0]       issue_addr;
    logic [3:0]            arbit_grant;
    logic [3:0][3:0]       arbit_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [3:0] valid;
        logic [15:0] addr;
        logic [3:0] grant;
        bit         all_addr;
    } exp_t;

    exp_t exp_q[$];

    iq_issue_select dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ent_busy    (ent_busy),
        .ent_issued  (ent_issued),
        .ent_rdy     (ent_rdy),
        .ent_age     (ent_age),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .arbit_grant (arbit_grant),
        .arbit_addr  (arbit_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] a4(input int a0, input int a1, input int a2, input int a3);
        return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ents();
        ent_busy   = '0;
        ent_issued = '0;
        ent_rdy    = '0;
        ent_age    = '0;
    endtask

    task automatic set_cand(input int i, input int age);
        ent_busy[i] = 1'b1;
        ent_rdy[i]  = 1'b1;
        ent_age[i]  = 5'(age);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] v, input logic [15:0] a,
                              input logic [3:0] g, input bit all_addr);
        exp_t e;
        e.tag      = tag;
        e.valid    = v;
        e.addr     = a;
        e.grant    = g;
        e.all_addr = all_addr;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty got=0 entries want>=1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (issue_valid === e.valid) else begin
                failures++;
                $error("FAIL %s issue_valid got=%b want=%b", e.tag, issue_valid, e.valid);
            end
            checks++;
            assert (arbit_grant === e.grant) else begin
                failures++;
                $error("FAIL %s arbit_grant got=%b want=%b", e.tag, arbit_grant, e.grant);
            end
            for (int j = 0; j < 4; j++) begin
                if (e.all_addr || e.valid[j]) begin
                    checks++;
                    assert (issue_addr[j] === e.addr[j*4 +: 4]) else begin
                        failures++;
                        $error("FAIL %s issue_addr[%0d] got=%0d want=%0d",
                               e.tag, j, issue_addr[j], e.addr[j*4 +: 4]);
                    end
                    checks++;
                    assert (arbit_addr[j] === e.addr[j*4 +: 4]) else begin
                        failures++;
                        $error("FAIL %s arbit_addr[%0d] got=%0d want=%0d",
                               e.tag, j, arbit_addr[j], e.addr[j*4 +: 4]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        fu_ready = 4'b0000;
        clear_ents();

        // reset state
        #2;
        expect_out("reset", 4'b0000, 16'h0000, 4'b0000, 1'b1);
        check_out();
        tick();
        tick();
        rst_n = 1'b1;

        // single pick
        set_cand(3, 7);
        fu_ready = 4'b1111;
        expect_out("single", 4'b0001, a4(3, 0, 0, 0), 4'b0001, 1'b0);
        tick();
        check_out();
        ent_issued[3] = 1'b1;
        expect_out("single_drain", 4'b0000, 16'h0000, 4'b0000, 1'b0);
        tick();
        check_out();

        // age ordering with an equal-age tie
        clear_ents();
        set_cand(2, 4);
        set_cand(5, 1);
        set_cand(9, 1);
        expect_out("order", 4'b0111, a4(5, 9, 2, 0), 4'b0111, 1'b0);
        tick();
        check_out();
        ent_issued[2] = 1'b1;
        ent_issued[5] = 1'b1;
        ent_issued[9] = 1'b1;
        expect_out("order_drain", 4'b0000, 16'h0000, 4'b0000, 1'b0);
        tick();
        check_out();

        // wrap-around: only port 0 frees up, entries 0 (age 30) and 1 (age 2) compete
        clear_ents();
        for (int i = 0; i < 4; i++) set_cand(4 + i, i);
        fu_ready = 4'b0000;
        expect_out("wrap_fill", 4'b1111, a4(4, 5, 6, 7), 4'b0000, 1'b0);
        tick();
        check_out();
        fu_ready = 4'b0001;
        set_cand(0, 30);
        set_cand(1, 2);
        expect_out("wrap_grant", 4'b1111, a4(4, 5, 6, 7), 4'b0001, 1'b0);
        #1;
        check_out();
        ent_issued[4] = 1'b1;
        expect_out("wrap_pick", 4'b1111, a4(0, 5, 6, 7), 4'b0001, 1'b0);
        tick();
        check_out();

        flush    = 1'b1;
        fu_ready = 4'b0000;
        clear_ents();
        expect_out("flush_clr", 4'b0000, 16'h0000, 4'b0000, 1'b0);
        tick();
        check_out();
        flush = 1'b0;

        // backpressure on port 0
        set_cand(4, 0);
        fu_ready = 4'b1110;
        expect_out("bp_load", 4'b0001, a4(4, 0, 0, 0), 4'b0000, 1'b0);
        tick();
        check_out();
        for (int k = 0; k < 3; k++) begin
            expect_out("bp_hold", 4'b0001, a4(4, 0, 0, 0), 4'b0000, 1'b0);
            tick();
            check_out();
        end
        fu_ready = 4'b1111;
        expect_out("bp_grant", 4'b0001, a4(4, 0, 0, 0), 4'b0001, 1'b0);
        #1;
        check_out();
        ent_issued[4] = 1'b1;
        expect_out("bp_drain", 4'b0000, 16'h0000, 4'b0000, 1'b0);
        tick();
        check_out();

        // overflow: 6 candidates, 4 ports
        clear_ents();
        set_cand(0, 5);
        set_cand(1, 0);
        set_cand(2, 3);
        set_cand(3, 1);
        set_cand(4, 4);
        set_cand(5, 2);
        fu_ready = 4'b0000;
        expect_out("ovf_fill", 4'b1111, a4(1, 3, 5, 2), 4'b0000, 1'b0);
        tick();
        check_out();
        fu_ready = 4'b0011;
        expect_out("ovf_grant", 4'b1111, a4(1, 3, 5, 2), 4'b0011, 1'b0);
        #1;
        check_out();
        ent_issued[1] = 1'b1;
        ent_issued[3] = 1'b1;
        expect_out("ovf_refill", 4'b1111, a4(4, 0, 5, 2), 4'b0011, 1'b0);
        tick();
        check_out();

        // free port 3 with nothing left, leaving three valid ports
        fu_ready = 4'b1000;
        expect_out("ovf_grant3", 4'b1111, a4(4, 0, 5, 2), 4'b1000, 1'b0);
        #1;
        check_out();
        ent_issued[2] = 1'b1;
        expect_out("flush_pre", 4'b0111, a4(4, 0, 5, 0), 4'b0000, 1'b0);
        tick();
        check_out();

        // flush: no grant while asserted, no load at the flushing edge
        flush    = 1'b1;
        fu_ready = 4'b1111;
        set_cand(9, 0);
        expect_out("flush_nogrant", 4'b0111, a4(4, 0, 5, 0), 4'b0000, 1'b0);
        #1;
        check_out();
        expect_out("flush_clear", 4'b0000, 16'h0000, 4'b0000, 1'b0);
        tick();
        check_out();
        flush = 1'b0;
        expect_out("post_flush", 4'b1111, a4(9, 5, 4, 0), 4'b1111, 1'b0);
        tick();
        check_out();

        // asynchronous reset mid-hold
        fu_ready = 4'b0000;
        #3;
        rst_n    = 1'b0;
        fu_ready = 4'b1111;
        #1;
        expect_out("rst_async", 4'b0000, 16'h0000, 4'b0000, 1'b1);
        check_out();
        clear_ents();
        set_cand(7, 3);
        tick();
        rst_n = 1'b1;
        expect_out("rst_first", 4'b0001, a4(7, 0, 0, 0), 4'b0001, 1'b0);
        tick();
        check_out();

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
